// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-register status in, stage enables out.
// slave = hazard_ctrl side, master = pipeline/testbench side.
interface hazard_ctrl_if #(
    parameter int INDEX = 5,
    parameter int CNT_W = 16
);
    logic             idex_mem_read_in;
    logic [INDEX-1:0] idex_rd_in;
    logic [INDEX-1:0] ifid_rs1_in;
    logic [INDEX-1:0] ifid_rs2_in;
    logic             ifid_use_rs1_in;
    logic             ifid_use_rs2_in;
    logic             ex_branch_taken_in;
    logic             dmem_req_in;
    logic             dmem_ready_in;
    logic             pc_write_out;
    logic             ifid_write_out;
    logic             ifid_flush_out;
    logic             idex_write_out;
    logic             idex_flush_out;
    logic             exmem_write_out;
    logic             memwb_flush_out;
    logic             mem_timeout_out;
    logic [CNT_W-1:0] stall_cnt_out;
    logic [CNT_W-1:0] flush_cnt_out;

    modport slave (
        input  idex_mem_read_in, idex_rd_in,
        input  ifid_rs1_in, ifid_rs2_in,
        input  ifid_use_rs1_in, ifid_use_rs2_in,
        input  ex_branch_taken_in,
        input  dmem_req_in, dmem_ready_in,
        output pc_write_out, ifid_write_out,
        output ifid_flush_out, idex_write_out,
        output idex_flush_out, exmem_write_out,
        output memwb_flush_out, mem_timeout_out,
        output stall_cnt_out, flush_cnt_out
    );

    modport master (
        output idex_mem_read_in, idex_rd_in,
        output ifid_rs1_in, ifid_rs2_in,
        output ifid_use_rs1_in, ifid_use_rs2_in,
        output ex_branch_taken_in,
        output dmem_req_in, dmem_ready_in,
        input  pc_write_out, ifid_write_out,
        input  ifid_flush_out, idex_write_out,
        input  idex_flush_out, exmem_write_out,
        input  memwb_flush_out, mem_timeout_out,
        input  stall_cnt_out, flush_cnt_out
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use bubble, branch flush and data-memory freeze with watchdog.
// Ports: clk, rst_n (async low), hz (hazard_ctrl_if.slave bundle).
module hazard_ctrl #(
    parameter int INDEX   = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    hazard_ctrl_if.slave hz
);
    localparam int WAIT_W = 12;
    localparam logic [WAIT_W-1:0] TO = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERR
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              timeout_q, timeout_d;

    logic load_use, mem_stall;
    logic pc_w, ifid_w, ifid_f;
    logic idex_w, idex_f, exmem_w, memwb_f;
    logic active;

    assign mem_stall = hz.dmem_req_in & ~hz.dmem_ready_in;

    assign load_use = hz.idex_mem_read_in
        & (hz.idex_rd_in != '0)
        & ((hz.ifid_use_rs1_in
            & (hz.idex_rd_in == hz.ifid_rs1_in))
         | (hz.ifid_use_rs2_in
            & (hz.idex_rd_in == hz.ifid_rs2_in)));

    always_comb begin
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        ifid_f  = 1'b0;
        idex_w  = 1'b1;
        idex_f  = 1'b0;
        exmem_w = 1'b1;
        memwb_f = 1'b0;
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    idex_w  = 1'b0;
                    exmem_w = 1'b0;
                    memwb_f = 1'b1;
                    if (state_q == RUN) begin
                        state_d = MEM_WAIT;
                        wait_d  = 12'd1;
                    end else if (wait_q == TO) begin
                        state_d = ERR;
                    end else begin
                        wait_d = wait_q + 12'd1;
                    end
                end else begin
                    // Dropped request counts as ready.
                    state_d = RUN;
                    wait_d  = '0;
                    if (hz.ex_branch_taken_in) begin
                        ifid_f = 1'b1;
                        idex_f = 1'b1;
                    end else if (load_use) begin
                        pc_w   = 1'b0;
                        ifid_w = 1'b0;
                        idex_f = 1'b1;
                    end
                end
            end
            ERR: begin
                pc_w    = 1'b0;
                ifid_w  = 1'b0;
                ifid_f  = 1'b1;
                idex_w  = 1'b0;
                idex_f  = 1'b1;
                exmem_w = 1'b0;
                memwb_f = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
        // Reset freezes the pipe combinationally.
        if (!rst_n) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            ifid_f  = 1'b1;
            idex_w  = 1'b0;
            idex_f  = 1'b1;
            exmem_w = 1'b0;
            memwb_f = 1'b1;
        end
    end

    assign active    = (state_q != ERR);
    assign timeout_d = timeout_q | (state_d == ERR);

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (active && !pc_w && (stall_q != '1))
            stall_d = stall_q + 1'b1;
        if (active && ifid_f && (flush_q != '1))
            flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            timeout_q <= timeout_d;
        end
    end

    assign hz.pc_write_out    = pc_w;
    assign hz.ifid_write_out  = ifid_w;
    assign hz.ifid_flush_out  = ifid_f;
    assign hz.idex_write_out  = idex_w;
    assign hz.idex_flush_out  = idex_f;
    assign hz.exmem_write_out = exmem_w;
    assign hz.memwb_flush_out = memwb_f;
    assign hz.mem_timeout_out = timeout_q;
    assign hz.stall_cnt_out   = stall_q;
    assign hz.flush_cnt_out   = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed vectors plus a per-cycle model.
// DUT built with TIMEOUT=4 and CNT_W=2 to reach watchdog and saturation.
module tb_hazard_ctrl;
    localparam int INDEX = 5;
    localparam int CNT_W = 2;
    localparam int TO    = 4;
    localparam int MAXC  = 3;

    // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f}
    localparam logic [6:0] DEFV = 7'b1101010;
    localparam logic [6:0] FRZV = 7'b0010101;
    localparam logic [6:0] MSTV = 7'b0000001;
    localparam logic [6:0] BRV  = 7'b1111110;
    localparam logic [6:0] LUV  = 7'b0001110;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_ctrl_if #(.INDEX(INDEX), .CNT_W(CNT_W)) bus ();

    hazard_ctrl #(
        .INDEX(INDEX), .CNT_W(CNT_W), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hz(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl();
        return {bus.pc_write_out, bus.ifid_write_out,
                bus.ifid_flush_out, bus.idex_write_out,
                bus.idex_flush_out, bus.exmem_write_out,
                bus.memwb_flush_out};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h t=%0t", nm, got, exp,
                     $time);
        end
    endtask

    // Model: outputs derived from the rule list, not from any FSM.
    bit  m_err, m_wait;
    int  m_w, m_sc, m_fc;
    logic [6:0] m_e;
    bit  m_ms, m_lu;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_err = 0; m_wait = 0; m_w = 0; m_sc = 0; m_fc = 0;
            m_e = FRZV;
        end else begin
            m_ms = bus.dmem_req_in && !bus.dmem_ready_in;
            m_lu = bus.idex_mem_read_in && bus.idex_rd_in != 0 &&
                   ((bus.ifid_use_rs1_in &&
                     bus.ifid_rs1_in == bus.idex_rd_in) ||
                    (bus.ifid_use_rs2_in &&
                     bus.ifid_rs2_in == bus.idex_rd_in));
            if (m_err) m_e = FRZV;
            else if (m_ms) m_e = MSTV;
            else if (bus.ex_branch_taken_in) m_e = BRV;
            else if (m_lu) m_e = LUV;
            else m_e = DEFV;
        end
        chk("m_ctl", 32'(ctl()), 32'(m_e));
        chk("m_tmo", 32'(bus.mem_timeout_out), 32'(m_err));
        chk("m_scnt", 32'(bus.stall_cnt_out), 32'(m_sc));
        chk("m_fcnt", 32'(bus.flush_cnt_out), 32'(m_fc));
        if (rst_n && !m_err) begin
            if (!m_e[6] && m_sc < MAXC) m_sc++;
            if (m_e[4] && m_fc < MAXC) m_fc++;
            if (m_ms) begin
                if (!m_wait) begin m_wait = 1; m_w = 1; end
                else if (m_w == TO) m_err = 1;
                else m_w++;
            end else begin
                m_wait = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.idex_mem_read_in   = 0;
        bus.idex_rd_in         = '0;
        bus.ifid_rs1_in        = '0;
        bus.ifid_rs2_in        = '0;
        bus.ifid_use_rs1_in    = 0;
        bus.ifid_use_rs2_in    = 0;
        bus.ex_branch_taken_in = 0;
        bus.dmem_req_in        = 0;
        bus.dmem_ready_in      = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        cyc();
        rst_n = 1;
    endtask

    task automatic load(input int rd, input int r1, input bit u1,
                        input int r2, input bit u2);
        bus.idex_mem_read_in = 1;
        bus.idex_rd_in       = INDEX'(rd);
        bus.ifid_rs1_in      = INDEX'(r1);
        bus.ifid_use_rs1_in  = u1;
        bus.ifid_rs2_in      = INDEX'(r2);
        bus.ifid_use_rs2_in  = u2;
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (2) cyc();
        chk("rst_ctl", 32'(ctl()), 32'(FRZV));
        chk("rst_scnt", 32'(bus.stall_cnt_out), 0);
        rst_n = 1;

        // load-use on rs2
        load(5, 3, 1, 5, 1);
        #3 chk("lu_ctl", 32'(ctl()), 32'(LUV));
        cyc(); idle();
        #3 chk("lu_next", 32'(ctl()), 32'(DEFV));
        chk("lu_scnt", 32'(bus.stall_cnt_out), 1);

        // x0 destination and unused operand
        do_reset();
        load(0, 0, 1, 0, 1);
        #3 chk("x0_ctl", 32'(ctl()), 32'(DEFV));
        cyc(); load(7, 7, 0, 1, 1);
        #3 chk("nouse_ctl", 32'(ctl()), 32'(DEFV));
        cyc(); idle();
        #3 chk("nouse_scnt", 32'(bus.stall_cnt_out), 0);
        // both operands match: single bubble
        cyc(); load(9, 9, 1, 9, 1);
        #3 chk("both_ctl", 32'(ctl()), 32'(LUV));
        cyc(); idle();
        #3 chk("both_scnt", 32'(bus.stall_cnt_out), 1);

        // branch beats load-use
        do_reset();
        load(5, 5, 1, 0, 0);
        bus.ex_branch_taken_in = 1;
        #3 chk("br_ctl", 32'(ctl()), 32'(BRV));
        cyc(); idle();
        #3 chk("br_fcnt", 32'(bus.flush_cnt_out), 1);
        chk("br_scnt", 32'(bus.stall_cnt_out), 0);

        // memory wait of 3 cycles
        do_reset();
        bus.dmem_req_in = 1;
        repeat (3) begin
            #3 chk("mw_ctl", 32'(ctl()), 32'(MSTV));
            cyc();
        end
        bus.dmem_ready_in = 1;
        #3 chk("mw_done", 32'(ctl()), 32'(DEFV));
        cyc(); idle();
        #3 chk("mw_scnt", 32'(bus.stall_cnt_out), 3);
        // wait ending with a taken branch
        cyc(); bus.dmem_req_in = 1;
        cyc(); bus.dmem_ready_in = 1; bus.ex_branch_taken_in = 1;
        #3 chk("mw_br", 32'(ctl()), 32'(BRV));
        cyc(); idle();

        // watchdog
        do_reset();
        bus.dmem_req_in = 1;
        repeat (5) begin
            #3 chk("wd_pre", 32'(bus.mem_timeout_out), 0);
            chk("wd_ctl", 32'(ctl()), 32'(MSTV));
            cyc();
        end
        #3 chk("wd_tmo", 32'(bus.mem_timeout_out), 1);
        chk("wd_frz", 32'(ctl()), 32'(FRZV));
        cyc(); bus.dmem_ready_in = 1;
        cyc(); idle();
        #3 chk("wd_stick", 32'(bus.mem_timeout_out), 1);
        chk("wd_frz2", 32'(ctl()), 32'(FRZV));
        cyc(); rst_n = 0;
        #1 chk("wd_clr", 32'(bus.mem_timeout_out), 0);
        cyc(); rst_n = 1;
        #3 chk("wd_run", 32'(ctl()), 32'(DEFV));

        // reset asserted mid-wait
        do_reset();
        bus.dmem_req_in = 1;
        repeat (2) cyc();
        rst_n = 0;
        #1 chk("rmw_ctl", 32'(ctl()), 32'(FRZV));
        chk("rmw_scnt", 32'(bus.stall_cnt_out), 0);
        cyc(); rst_n = 1; idle();
        #3 chk("rmw_run", 32'(ctl()), 32'(DEFV));
        cyc(); bus.dmem_req_in = 1;
        #3 chk("rmw_st", 32'(ctl()), 32'(MSTV));
        cyc(); bus.dmem_ready_in = 1;
        #3 chk("rmw_end", 32'(ctl()), 32'(DEFV));
        cyc(); idle();

        // saturation
        do_reset();
        load(4, 4, 1, 0, 0);
        repeat (5) cyc();
        idle();
        #3 chk("sat_scnt", 32'(bus.stall_cnt_out), 3);
        cyc(); bus.ex_branch_taken_in = 1;
        repeat (5) cyc();
        idle();
        #3 chk("sat_fcnt", 32'(bus.flush_cnt_out), 3);

        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
